// File: rtl/slot_request_arbiter.sv
// Merges NUM_IN slot request streams onto one VFU issue port (round-robin or fixed priority); SLOT_REQUEST_ARBITER_PERF_EN adds stall_count/grant_hist.
// Latency 1 cycle through the output register, 1 request/cycle sustained; a stalled output holds its contents and drops every in_ready.
module slot_request_arbiter #(
  parameter int NUM_IN      = 4,
  parameter int PAYLOAD_W   = 206,
  parameter int ROUND_ROBIN = 1,
  localparam int SRC_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_IN-1:0]           in_valid,
  output logic [NUM_IN-1:0]           in_ready,
  input  logic [NUM_IN*PAYLOAD_W-1:0] in_bits,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PAYLOAD_W-1:0]        out_bits,
  output logic [SRC_W-1:0]            out_source
`ifdef SLOT_REQUEST_ARBITER_PERF_EN
  ,
  output logic [31:0]                 stall_count,
  output logic [NUM_IN-1:0]           grant_hist
`endif
);

  logic [SRC_W-1:0]     rr_ptr;
  logic [SRC_W-1:0]     grant_idx;
  logic [SRC_W-1:0]     next_ptr;
  logic [NUM_IN-1:0]    ptr_onehot;
  logic [NUM_IN-1:0]    upper_mask;
  logic [NUM_IN-1:0]    req_upper;
  logic [NUM_IN-1:0]    req;
  logic [NUM_IN-1:0]    grant;
  logic [PAYLOAD_W-1:0] grant_bits;
  logic                 stage_free;
  logic                 xfer;

  // Requests at or above rr_ptr take precedence; if none, wrap to the full set.
  always_comb begin
    ptr_onehot = NUM_IN'(1) << rr_ptr;
    upper_mask = ~(ptr_onehot - NUM_IN'(1));
    req_upper  = in_valid & upper_mask;
    if ((ROUND_ROBIN != 0) && (req_upper != '0)) begin
      req = req_upper;
    end else begin
      req = in_valid;
    end
    grant = req & (~req + NUM_IN'(1));
  end

  always_comb begin
    grant_idx  = '0;
    grant_bits = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) begin
        grant_idx  = SRC_W'(i);
        grant_bits = in_bits[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  always_comb begin
    next_ptr   = (grant_idx == SRC_W'(NUM_IN - 1)) ? '0 : grant_idx + SRC_W'(1);
    stage_free = !out_valid || out_ready;
    xfer       = reset && stage_free && (grant != '0);
    in_ready   = (reset && stage_free) ? grant : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_bits   <= '0;
      out_source <= '0;
      rr_ptr     <= '0;
    end else if (xfer) begin
      out_valid  <= 1'b1;
      out_bits   <= grant_bits;
      out_source <= grant_idx;
      rr_ptr     <= (ROUND_ROBIN != 0) ? next_ptr : '0;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef SLOT_REQUEST_ARBITER_PERF_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_count <= '0;
      grant_hist  <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_count != 32'hFFFF_FFFF)) begin
        stall_count <= stall_count + 32'd1;
      end
      if (xfer) begin
        grant_hist <= grant;
      end
    end
  end
`endif

endmodule

// File: tb/tb_slot_request_arbiter.sv
// Round-robin and fixed-priority arbiters driven in parallel against a queue-based reference model.
module tb_slot_request_arbiter;
  localparam int N  = 4;
  localparam int PW = 206;

  typedef struct packed {
    logic [PW-1:0] bits;
    logic [1:0]    src;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    in_valid = '0;
  logic            out_ready = 1'b0;
  logic [PW-1:0]   pay [N];
  logic [N*PW-1:0] in_bits;

  logic            ov [2];
  logic [PW-1:0]   ob [2];
  logic [1:0]      os [2];
  logic [N-1:0]    ir [2];
`ifdef SLOT_REQUEST_ARBITER_PERF_EN
  logic [31:0]     sc [2];
  logic [N-1:0]    gh [2];
  logic [31:0]     exp_stall [2];
`endif

  always_comb in_bits = {pay[3], pay[2], pay[1], pay[0]};

  slot_request_arbiter #(.NUM_IN(N), .PAYLOAD_W(PW), .ROUND_ROBIN(1)) dut_rr (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .in_bits(in_bits),
    .out_valid(ov[0]), .out_ready(out_ready), .out_bits(ob[0]), .out_source(os[0])
`ifdef SLOT_REQUEST_ARBITER_PERF_EN
    , .stall_count(sc[0]), .grant_hist(gh[0])
`endif
  );

  slot_request_arbiter #(.NUM_IN(N), .PAYLOAD_W(PW), .ROUND_ROBIN(0)) dut_fp (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .in_bits(in_bits),
    .out_valid(ov[1]), .out_ready(out_ready), .out_bits(ob[1]), .out_source(os[1])
`ifdef SLOT_REQUEST_ARBITER_PERF_EN
    , .stall_count(sc[1]), .grant_hist(gh[1])
`endif
  );

  always #5 clock = ~clock;

  exp_t         q_rr [$];
  exp_t         q_fp [$];
  int           ptr [2];
  exp_t         pend [2];
  bit           pend_vld [2];
  bit           clr [2];
  logic [N-1:0] exp_rdy [2];
  logic [N-1:0] exp_hist [2];
  bit           zero_chk = 1'b0;
  bit           started = 1'b0;
  int           checks = 0;
  int           passes = 0;

  function automatic int qsize(int m);
    return (m == 0) ? q_rr.size() : q_fp.size();
  endfunction

  function automatic exp_t qfront(int m);
    return (m == 0) ? q_rr[0] : q_fp[0];
  endfunction

  task automatic qpush(input int m, input exp_t e);
    if (m == 0) q_rr.push_back(e); else q_fp.push_back(e);
  endtask

  task automatic qpop(input int m);
    if (m == 0) void'(q_rr.pop_front()); else void'(q_fp.pop_front());
  endtask

  task automatic qclear(input int m);
    if (m == 0) q_rr.delete(); else q_fp.delete();
  endtask

  // Model 0 is round-robin from its pointer, model 1 is lowest index first.
  function automatic int model_grant(int m, logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int idx = (m == 0) ? (ptr[m] + k) % N : k;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [PW-1:0] rand_pay();
    logic [PW-1:0] p = '0;
    for (int i = 0; i < 7; i++) p = {p[PW-33:0], 32'($urandom)};
    return p;
  endfunction

  task automatic chk(input int m, input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL dut%0d %s: got %0h expected %0h", m, nm, act, exp);
  endtask

  task automatic step(input logic r, input logic [N-1:0] v, input logic ordy, input bit randpay);
    @(posedge clock);
    #1;
    zero_chk = !reset;
    for (int m = 0; m < 2; m++) begin
      if (clr[m]) begin
        qclear(m);
        exp_hist[m] = '0;
      end else if (pend_vld[m]) begin
        qpush(m, pend[m]);
        exp_hist[m] = N'(1) << pend[m].src;
      end
      clr[m]      = 1'b0;
      pend_vld[m] = 1'b0;
    end
    if (randpay) for (int i = 0; i < N; i++) pay[i] = rand_pay();
    reset     = r;
    in_valid  = v;
    out_ready = ordy;
    started   = 1'b1;
    for (int m = 0; m < 2; m++) begin
      exp_rdy[m] = '0;
      if (!r) begin
        clr[m] = 1'b1;
        ptr[m] = 0;
      end else begin
        int g = model_grant(m, v);
        if (g >= 0 && (qsize(m) == 0 || ordy)) begin
          exp_rdy[m]  = N'(1) << g;
          pend[m]     = '{bits: pay[g], src: 2'(g)};
          pend_vld[m] = 1'b1;
          if (m == 0) ptr[m] = (g + 1) % N;
        end
      end
    end
  endtask

  task automatic check_port(input int m);
    exp_t e;
    chk(m, "in_ready", 256'(ir[m]), 256'(exp_rdy[m]));
    if (zero_chk) begin
      chk(m, "reset_out_valid", 256'(ov[m]), 256'(0));
      chk(m, "reset_out_bits", 256'(ob[m]), 256'(0));
      chk(m, "reset_out_source", 256'(os[m]), 256'(0));
    end
    if (qsize(m) > 0) begin
      e = qfront(m);
      chk(m, "out_valid", 256'(ov[m]), 256'(1));
      chk(m, "out_bits", 256'(ob[m]), 256'(e.bits));
      chk(m, "out_source", 256'(os[m]), 256'(e.src));
      if (ov[m] && out_ready) qpop(m);
    end else begin
      chk(m, "out_valid_idle", 256'(ov[m]), 256'(0));
    end
`ifdef SLOT_REQUEST_ARBITER_PERF_EN
    chk(m, "stall_count", 256'(sc[m]), 256'(exp_stall[m]));
    chk(m, "grant_hist", 256'(gh[m]), 256'(exp_hist[m]));
    if (!reset) exp_stall[m] = '0;
    else if (ov[m] && !out_ready && exp_stall[m] != 32'hFFFF_FFFF) exp_stall[m] = exp_stall[m] + 32'd1;
`endif
  endtask

  always @(negedge clock) begin
    if (started) begin
      for (int m = 0; m < 2; m++) check_port(m);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      ptr[m] = 0; pend_vld[m] = 1'b0; clr[m] = 1'b0;
      exp_rdy[m] = '0; exp_hist[m] = '0;
`ifdef SLOT_REQUEST_ARBITER_PERF_EN
      exp_stall[m] = '0;
`endif
    end
    for (int i = 0; i < N; i++) pay[i] = PW'(i + 'hA0);

    // Reset held with every channel requesting.
    repeat (3) step(1'b0, 4'b1111, 1'b1, 1'b0);
    // Rotation over all channels, full throughput.
    repeat (6) step(1'b1, 4'b1111, 1'b1, 1'b0);
    // Channels 1 and 3 only: fixed priority starves 3.
    repeat (4) step(1'b1, 4'b1010, 1'b1, 1'b0);

    // Park channel 2 in the output, stall for 5 cycles, then release.
    step(1'b0, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 4'b0100, 1'b1, 1'b0);
    repeat (5) step(1'b1, 4'b1111, 1'b0, 1'b0);
    repeat (2) step(1'b1, 4'b1111, 1'b1, 1'b0);

    // Single-cycle request from channel 2, then 0 and 3 compete.
    repeat (2) step(1'b1, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 4'b0100, 1'b1, 1'b0);
    repeat (2) step(1'b1, 4'b0000, 1'b1, 1'b0);
    repeat (3) step(1'b1, 4'b1001, 1'b1, 1'b0);

    // Mid-transfer reset while stalled.
    repeat (2) step(1'b1, 4'b1111, 1'b0, 1'b0);
    step(1'b0, 4'b1111, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 1'b1, 1'b0);

    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 59) != 0), 4'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
    end

    repeat (4) step(1'b1, 4'b0000, 1'b1, 1'b0);
    @(posedge clock);
    #1;
    chk(0, "drained", 256'(q_rr.size()), 256'(0));
    chk(1, "drained", 256'(q_fp.size()), 256'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/slot_request_arbiter.md
Name: slot_request_arbiter

Overview:
- N-input arbiter for packed slot-to-VFU requests, with a registered output stage.
- Merges per-slot request streams into one VFU issue port.
- Generalises the single-input pass-through arbiter with:
  - parametrised channel count and payload width,
  - selectable round-robin or fixed-priority arbitration,
  - a one-cycle registered output that sustains full throughput,
  - the winning source index on the output.

Parameters:
- NUM_IN, 4, number of request channels (1..16).
- PAYLOAD_W, 206, packed request width (src_0..3, opcode, masks, control fields, tag).
- ROUND_ROBIN, 1, 1 = round-robin; 0 = fixed priority, lowest index wins.
- SRC_W, max(1,$clog2(NUM_IN)), width of the source index (derived; do not override).

Ports:
- clock  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- in_valid  input  NUM_IN  per-channel request valid.
- in_ready  output  NUM_IN  per-channel accept; at most one bit high per cycle.
- in_bits  input  NUM_IN*PAYLOAD_W  channel i occupies bits [i*PAYLOAD_W +: PAYLOAD_W].
- out_valid  output  1  registered request valid.
- out_ready  input  1  VFU accept.
- out_bits  output  PAYLOAD_W  registered payload.
- out_source  output  SRC_W  index of the channel that supplied out_bits.

Behaviour:
- Reset (reset==0 at a clock edge): out_valid=0, out_bits=0, out_source=0, rr_ptr=0. in_ready is combinational and evaluates to 0 while out_valid=0 and no input is valid.
- Reset asserted mid-transfer discards the held request. No handshake completes on a reset cycle: in_ready is forced to 0 while reset==0.
- Accept condition: stage_free = !out_valid || out_ready.
- Grant:
  - ROUND_ROBIN=1: first valid channel searching from rr_ptr upward, wrapping NUM_IN-1 -> 0.
  - ROUND_ROBIN=0: lowest-index valid channel.
- in_ready[i] = grant[i] && stage_free. in_ready never depends on in_valid of another channel beyond the grant.
- Transfer on in_valid[i] && in_ready[i]:
  - next cycle out_valid=1, out_bits=in_bits[i], out_source=i.
  - Latency 1 cycle, throughput 1 per cycle when out_ready is held high.
- Output dequeue (out_valid && out_ready) with no new grant: out_valid=0 next cycle; out_bits/out_source hold their last value.
- Simultaneous dequeue and new grant in the same cycle: the register is overwritten; no bubble.
- Stall (out_valid && !out_ready):
  - out_valid, out_bits, out_source are stable.
  - all in_ready=0.
  - rr_ptr unchanged.
- rr_ptr update (ROUND_ROBIN=1): only on a transfer; rr_ptr <= (granted index + 1) mod NUM_IN. No update when no transfer occurs.
- ROUND_ROBIN=0: rr_ptr is unused and held at 0.
- NUM_IN=1: degenerates to a single registered stage; out_source is constant 0.
- Input payload is sampled only on the transfer cycle. A non-granted channel may change in_bits freely.

Optional Feature:
- Macro: SLOT_REQUEST_ARBITER_PERF_EN.
- Defined: adds output port stall_count [31:0].
  - Increments by 1 on every cycle with out_valid && !out_ready.
  - Saturates at 0xFFFFFFFF; cleared to 0 by reset.
  - Also adds output grant_hist [NUM_IN-1:0], a one-hot register of the last granted channel, reset 0.
- Undefined: neither port nor the counter logic exists; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 3 cycles with all in_valid=1 -> out_valid=0, out_bits=0, out_source=0, in_ready=0000 throughout; first edge after reset=1 grants channel 0.
- Round-robin fairness (NUM_IN=4, ROUND_ROBIN=1, out_ready=1, all in_valid=1 with in_bits[i]=i+0xA0): out_source sequence 0,1,2,3,0,1; out_bits 0xA0,0xA1,0xA2,0xA3 per cycle; no bubbles.
- Fixed priority (ROUND_ROBIN=0, in_valid=1010): channel 1 granted every cycle; channel 3 starves; in_ready=0010.
- Backpressure: with out_valid=1 and out_source=2, hold out_ready=0 for 5 cycles while in_valid=1111 -> in_ready=0000 and out_bits stable; on out_ready=1, channel 3 is granted in that same cycle and appears next cycle.
- Sparse traffic: in_valid=0100 for 1 cycle, then 0000 -> out_valid high exactly 1 cycle with out_source=2; rr_ptr becomes 3, so a later in_valid=1001 grants channel 3 first.
- Perf (macro defined): 7 stall cycles -> stall_count=7, grant_hist matches the last out_source one-hot; reset returns both to 0.
